// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: shared types for the sequential ALU core.
//   alu_op_t    - 3-bit opcode as presented on the op port
//   alu_state_t - control FSM states of alu_seq_core
package alu_seq_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_MUL = 3'b101,
    OP_DIV = 3'b110,
    OP_CMP = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

endpackage

// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: iterative unsigned multiply (shift-add) / restoring divide.
//   clk, rst  - clock, synchronous active-high reset
//   start     - load operands; first iteration is applied on this same edge
//   is_div    - 1: divide a/b, 0: multiply a*b
//   a, b      - operands (sampled on start)
//   done      - one-cycle pulse once all WIDTH iterations have been applied
//   hi, lo    - MUL: product high/low; DIV: remainder/quotient
// Only instantiated when ALU_SEQ_MULDIV_EN is defined.
module alu_seq_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0] acc_q, sh_q, b_q;
  logic             div_q, busy_q, done_q;
  logic [CNT_W-1:0] cnt_q;

  logic [WIDTH-1:0] acc_in, sh_in, b_in, acc_nx, sh_nx, diff;
  logic             div_in;
  logic [WIDTH:0]   sum, shifted;

  // Iteration operands come straight from the ports on start so the first
  // step overlaps the load; the FSM then sees exactly WIDTH busy cycles.
  always_comb begin
    acc_in  = start ? '0 : acc_q;
    sh_in   = start ? a : sh_q;
    b_in    = start ? b : b_q;
    div_in  = start ? is_div : div_q;
    sum     = {1'b0, acc_in} + (sh_in[0] ? {1'b0, b_in} : '0);
    shifted = {acc_in, sh_in[WIDTH-1]};
    // Only used when shifted >= b, where the true difference is < b and fits.
    diff    = shifted[WIDTH-1:0] - b_in;
    if (div_in) begin
      if (shifted >= {1'b0, b_in}) begin
        acc_nx = diff;
        sh_nx  = {sh_in[WIDTH-2:0], 1'b1};
      end else begin
        acc_nx = shifted[WIDTH-1:0];
        sh_nx  = {sh_in[WIDTH-2:0], 1'b0};
      end
    end else begin
      // {acc,sh} shifts right with the carry-out of the partial sum on top.
      acc_nx = sum[WIDTH:1];
      sh_nx  = {sum[0], sh_in[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q  <= '0;
      sh_q   <= '0;
      b_q    <= '0;
      div_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      done_q <= 1'b0;
      if (start) begin
        acc_q  <= acc_nx;
        sh_q   <= sh_nx;
        b_q    <= b;
        div_q  <= is_div;
        busy_q <= 1'b1;
        cnt_q  <= CNT_W'(1);
      end else if (busy_q) begin
        acc_q <= acc_nx;
        sh_q  <= sh_nx;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + CNT_W'(1);
        end
      end
    end
  end

  assign done = done_q;
  assign hi   = acc_q;
  assign lo   = sh_q;

endmodule

// File: rtl/alu_seq_core.sv
// alu_seq_core: multi-cycle unsigned ALU with valid/ready in and out.
//   clk, rst             - clock, synchronous active-high reset
//   in_valid/in_ready    - operation handshake (in_ready = IDLE && !rst)
//   op, a, b             - opcode and unsigned operands
//   out_valid/out_ready  - result handshake
//   result, result_hi    - low/quotient and high/remainder words
//   carry, zero, error   - flags, all registered
// Build option: define ALU_SEQ_MULDIV_EN to include the iterative MUL/DIV
// engine; without it MUL/DIV complete in one cycle with error=1.
module alu_seq_core
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             carry,
  output logic             zero,
  output logic             error
);

  alu_state_t       state_q, state_d;
  logic [WIDTH-1:0] res_q, res_d, hi_q, hi_d;
  logic             carry_q, carry_d, zero_q, zero_d, err_q, err_d;
  logic             vld_q, vld_d;
  logic             accept;
  logic [WIDTH:0]   add_sum;
  alu_op_t          op_e;

`ifdef ALU_SEQ_MULDIV_EN
  logic             eng_start, eng_done;
  logic [WIDTH-1:0] eng_hi, eng_lo;
  logic             mul_q, mul_d;

  alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk    (clk),
    .rst    (rst),
    .start  (eng_start),
    .is_div (op_e == OP_DIV),
    .a      (a),
    .b      (b),
    .done   (eng_done),
    .hi     (eng_hi),
    .lo     (eng_lo)
  );
`endif

  assign in_ready = (state_q == ST_IDLE) && !rst;
  assign accept   = in_valid && in_ready;
  assign op_e     = alu_op_t'(op);
  assign add_sum  = {1'b0, a} + {1'b0, b};

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    hi_d    = hi_q;
    carry_d = carry_q;
    err_d   = err_q;
    vld_d   = vld_q;
`ifdef ALU_SEQ_MULDIV_EN
    eng_start = 1'b0;
    mul_d     = mul_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_DONE;
          vld_d   = 1'b1;
          hi_d    = '0;
          carry_d = 1'b0;
          err_d   = 1'b0;
          case (op_e)
            OP_ADD: {carry_d, res_d} = add_sum;
            OP_SUB: begin
              res_d   = a - b;
              carry_d = (a < b);
            end
            OP_AND: res_d = a & b;
            OP_OR:  res_d = a | b;
            OP_XOR: res_d = a ^ b;
            OP_CMP: begin
              res_d   = {{(WIDTH-1){1'b0}}, (a == b)};
              carry_d = (a < b);
            end
            default: begin // MUL, DIV
`ifdef ALU_SEQ_MULDIV_EN
              if (op_e == OP_DIV && b == '0) begin
                res_d = '0;
                hi_d  = a;
                err_d = 1'b1;
              end else begin
                // Result words stay as-is until the engine finishes.
                state_d   = ST_BUSY;
                vld_d     = 1'b0;
                res_d     = res_q;
                hi_d      = hi_q;
                eng_start = 1'b1;
                mul_d     = (op_e == OP_MUL);
              end
`else
              res_d = '0;
              err_d = 1'b1;
`endif
            end
          endcase
        end
      end
      ST_BUSY: begin
`ifdef ALU_SEQ_MULDIV_EN
        if (eng_done) begin
          state_d = ST_DONE;
          vld_d   = 1'b1;
          res_d   = eng_lo;
          hi_d    = eng_hi;
          carry_d = mul_q && (eng_hi != '0);
          err_d   = 1'b0;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
          vld_d   = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    zero_d = ({hi_d, res_d} == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      hi_q    <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
      mul_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      hi_q    <= hi_d;
      carry_q <= carry_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
`ifdef ALU_SEQ_MULDIV_EN
      mul_q   <= mul_d;
`endif
    end
  end

  assign out_valid = vld_q;
  assign result    = res_q;
  assign result_hi = hi_q;
  assign carry     = carry_q;
  assign zero      = zero_q;
  assign error     = err_q;

endmodule

// File: tb/tb_alu_seq_core.sv
// tb_alu_seq_core: directed self-checking bench for alu_seq_core.
// WIDTH follows the build: 8 with ALU_SEQ_MULDIV_EN, 16 without.
module tb_alu_seq_core;

`ifdef ALU_SEQ_MULDIV_EN
  localparam int W = 8;
`else
  localparam int W = 16;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [2:0]   op;
  logic [W-1:0] a, b, result, result_hi;
  logic         carry, zero, error;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  alu_seq_core #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .carry     (carry),
    .zero      (zero),
    .error     (error)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Present one op, then count edges until out_valid (bounded).
  task automatic run_op(input logic [2:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int lat);
    @(negedge clk);
    in_valid = 1'b1; op = o; a = x; b = y;
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
      if (out_valid) break;
    end
    if (!out_valid) lat = -1;
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("drop_valid", out_valid, 0);
    chk("ready_back", in_ready, 1);
  endtask

  task automatic check_res(input string tag, input int lat, input int exp_lat,
                           input logic [W-1:0] r, input logic [W-1:0] h,
                           input logic c, input logic z, input logic e);
    chk({tag, "_lat"},   lat, exp_lat);
    chk({tag, "_res"},   result, r);
    chk({tag, "_hi"},    result_hi, h);
    chk({tag, "_carry"}, carry, c);
    chk({tag, "_zero"},  zero, z);
    chk({tag, "_err"},   error, e);
    release_out();
  endtask

  initial begin
    int lat;
    logic [W-1:0] hold_res;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = '0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_res", result, 0);
    chk("rst_hi", result_hi, 0);
    chk("rst_flags", {carry, zero, error}, 0);
    chk("rst_in_ready", in_ready, 0);
    @(negedge clk); rst = 1'b0;
    #1 chk("idle_ready", in_ready, 1);

`ifdef ALU_SEQ_MULDIV_EN
    run_op(3'b000, 8'd200, 8'd100, lat); check_res("add", lat, 1, 8'd44, 0, 1, 0, 0);
    run_op(3'b001, 8'd5, 8'd7, lat);     check_res("sub", lat, 1, 8'd254, 0, 1, 0, 0);
    run_op(3'b111, 8'd9, 8'd9, lat);     check_res("cmp", lat, 1, 8'd1, 0, 0, 0, 0);
    run_op(3'b010, 8'hF0, 8'h3C, lat);   check_res("and", lat, 1, 8'h30, 0, 0, 0, 0);
    run_op(3'b100, 8'hAA, 8'hAA, lat);   check_res("xor", lat, 1, 8'h00, 0, 0, 1, 0);
    run_op(3'b011, 8'h81, 8'h42, lat);   check_res("or", lat, 1, 8'hC3, 0, 0, 0, 0);
    run_op(3'b101, 8'd255, 8'd255, lat); check_res("mul", lat, 9, 8'd1, 8'd254, 1, 0, 0);
    run_op(3'b101, 8'd12, 8'd10, lat);   check_res("mul_small", lat, 9, 8'd120, 0, 0, 0, 0);
    run_op(3'b101, 8'd0, 8'd77, lat);    check_res("mul_zero", lat, 9, 0, 0, 0, 1, 0);
    run_op(3'b110, 8'd200, 8'd7, lat);   check_res("div", lat, 9, 8'd28, 8'd4, 0, 0, 0);
    run_op(3'b110, 8'd3, 8'd250, lat);   check_res("div_lt", lat, 9, 0, 8'd3, 0, 0, 0);
    run_op(3'b110, 8'd13, 8'd0, lat);    check_res("div0", lat, 1, 0, 8'd13, 0, 0, 1);
`else
    run_op(3'b101, 16'd3, 16'd4, lat);     check_res("mul_off", lat, 1, 0, 0, 0, 1, 1);
    run_op(3'b110, 16'd10, 16'd2, lat);    check_res("div_off", lat, 1, 0, 0, 0, 1, 1);
    run_op(3'b000, 16'd65535, 16'd1, lat); check_res("add_wrap", lat, 1, 0, 0, 1, 1, 0);
    run_op(3'b001, 16'd3, 16'd5, lat);     check_res("sub", lat, 1, 16'd65534, 0, 1, 0, 0);
    run_op(3'b111, 16'd4, 16'd9, lat);     check_res("cmp_lt", lat, 1, 0, 0, 1, 1, 0);
    run_op(3'b010, 16'hFF00, 16'h0FF0, lat); check_res("and", lat, 1, 16'h0F00, 0, 0, 0, 0);
`endif

    // Hold in DONE: outputs stable, new input ignored.
    run_op(3'b000, W'(3), W'(4), lat);
    chk("hold_lat", lat, 1);
    hold_res = result;
    chk("hold_first", hold_res, 7);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = 1'b1; op = 3'b011; a = W'(9); b = W'(6);
      @(posedge clk); #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_res", result, 7);
      chk("hold_in_ready", in_ready, 0);
    end
    @(negedge clk) in_valid = 1'b0;
    release_out();

    // Reset during a long op (or right after accept when MUL/DIV is absent).
    @(negedge clk);
    in_valid = 1'b1; op = 3'b101; a = W'(7); b = W'(9);
    @(posedge clk); #1;
    in_valid = 1'b0;
`ifdef ALU_SEQ_MULDIV_EN
    repeat (3) @(posedge clk);
`endif
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_valid", out_valid, 0);
    chk("abort_res", result, 0);
    chk("abort_hi", result_hi, 0);
    @(negedge clk) rst = 1'b0;
    #1 chk("abort_ready", in_ready, 1);
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(posedge clk); #1;
        if (out_valid) seen = 1'b1;
      end
      chk("abort_no_valid", seen, 0);
    end

    // Usable again after the abort.
    run_op(3'b100, W'(5), W'(3), lat);
    check_res("post_abort", lat, 1, W'(6), 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
